// File: rtl/aes_pkg.sv
// Shared AES constants and the canonical state-word type.
package aes_pkg;

  localparam int unsigned AES_BYTE_W      = 8;
  localparam int unsigned AES_BLOCK_BYTES = 16;

  typedef logic [AES_BLOCK_BYTES-1:0][AES_BYTE_W-1:0] aes_state_t;

endpackage

// File: rtl/mod_ptr_ctr.sv
// Wrapping pointer counter: counts 0..MAX and wraps to 0; clr wins over inc.
module mod_ptr_ctr #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned MAX   = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_val
);

  logic [WIDTH-1:0] r_val;

  // Pointer register with synchronous clear and explicit wrap at MAX
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_val <= '0;
    end else if (i_clr) begin
      r_val <= '0;
    end else if (i_inc) begin
      r_val <= (r_val == WIDTH'(MAX)) ? '0 : r_val + WIDTH'(1);
    end
  end

  assign o_val = r_val;

endmodule

// File: rtl/mod_statebuf.sv
// First-word-fall-through queue of AES state words with valid/ready on both sides.
module mod_statebuf
  import aes_pkg::*;
#(
  parameter int unsigned N_BYTES = AES_BLOCK_BYTES,
  parameter int unsigned BYTE_W  = AES_BYTE_W,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [N_BYTES-1:0][BYTE_W-1:0]  i,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [N_BYTES-1:0][BYTE_W-1:0]  o,
  output logic [$clog2(DEPTH+1)-1:0]      count,
  output logic                            reg_full,
  output logic                            reg_empty,
  output logic                            err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [N_BYTES-1:0][BYTE_W-1:0] r_mem [DEPTH];
  logic [CW-1:0]                  r_count;
  logic [CW-1:0]                  w_count_d;
  logic                           r_err;
  logic                           r_prev_stall;
  logic [PW-1:0]                  w_wptr;
  logic [PW-1:0]                  w_rptr;
  logic                           w_push;
  logic                           w_pop;

  // Flags come from the registered count only, so in_ready never depends on out_ready
  assign reg_full  = (r_count == CW'(DEPTH));
  assign reg_empty = (r_count == '0);
  assign in_ready  = !reg_full;
  assign out_valid = !reg_empty;
  assign count     = r_count;
  assign err       = r_err;

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  assign o = out_valid ? r_mem[w_rptr] : '0;

  mod_ptr_ctr #(
    .WIDTH (PW),
    .MAX   (DEPTH - 1)
  ) u_wptr (
    .clk    (clk),
    .resetn (resetn),
    .i_clr  (flush),
    .i_inc  (w_push),
    .o_val  (w_wptr)
  );

  mod_ptr_ctr #(
    .WIDTH (PW),
    .MAX   (DEPTH - 1)
  ) u_rptr (
    .clk    (clk),
    .resetn (resetn),
    .i_clr  (flush),
    .i_inc  (w_pop),
    .o_val  (w_rptr)
  );

  // Next occupancy: simultaneous push and pop leave it unchanged
  always_comb begin
    w_count_d = r_count;
    if (w_push && !w_pop) begin
      w_count_d = r_count + CW'(1);
    end else if (w_pop && !w_push) begin
      w_count_d = r_count - CW'(1);
    end
  end

  // Occupancy and sticky hold-rule violation tracking
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count      <= '0;
      r_err        <= 1'b0;
      r_prev_stall <= 1'b0;
    end else if (flush) begin
      r_count      <= '0;
      r_err        <= 1'b0;
      r_prev_stall <= 1'b0;
    end else begin
      r_count      <= w_count_d;
      // A stalled offer must be held until accepted
      r_prev_stall <= in_valid && !in_ready;
      if (r_prev_stall && !in_valid) begin
        r_err <= 1'b1;
      end
    end
  end

  // Storage array; zeroed on reset and flush so no stale data survives
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        r_mem[k] <= '0;
      end
    end else if (flush) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        r_mem[k] <= '0;
      end
    end else if (w_push) begin
      r_mem[w_wptr] <= i;
    end
  end

endmodule

// File: tb/tb_mod_statebuf.sv
// Bench for mod_statebuf: queue-based reference model plus directed scenarios.
module tb_mod_statebuf;
  import aes_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  aes_state_t i = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  aes_state_t o;
  logic [2:0] count;
  logic       reg_full;
  logic       reg_empty;
  logic       err;

  int total = 0;
  int bad   = 0;

  mod_statebuf #(
    .N_BYTES (16),
    .BYTE_W  (8),
    .DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .i         (i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o         (o),
    .count     (count),
    .reg_full  (reg_full),
    .reg_empty (reg_empty),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Word whose byte k holds base+k
  function automatic aes_state_t mk(input int base);
    aes_state_t w;
    for (int k = 0; k < 16; k++) w[k] = 8'(base + k);
    return w;
  endfunction

  // Reference model: a plain bounded queue plus the hold-rule watcher
  aes_state_t q[$];
  bit m_err = 0;
  bit m_prev = 0;
  bit m_full, m_pop, m_push;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q.delete();
      m_err  = 0;
      m_prev = 0;
    end else if (flush) begin
      q.delete();
      m_err  = 0;
      m_prev = 0;
    end else begin
      m_full = (q.size() == DEPTH);
      m_pop  = (q.size() != 0) && out_ready;
      m_push = in_valid && !m_full;
      if (m_prev && !in_valid) m_err = 1;
      m_prev = in_valid && m_full;
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back(i);
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (resetn) begin
      chk("o", o, (q.size() != 0) ? q[0] : '0);
      chk("out_valid", 128'(out_valid), 128'(q.size() != 0));
      chk("in_ready", 128'(in_ready), 128'(q.size() != DEPTH));
      chk("count", 128'(count), 128'(q.size()));
      chk("reg_full", 128'(reg_full), 128'(q.size() == DEPTH));
      chk("reg_empty", 128'(reg_empty), 128'(q.size() == 0));
      chk("err", 128'(err), 128'(m_err));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
    chk({tag, "_o"}, o, 128'(0));
    chk({tag, "_count"}, 128'(count), 128'(0));
    chk({tag, "_full"}, 128'(reg_full), 128'(0));
    chk({tag, "_empty"}, 128'(reg_empty), 128'(1));
    chk({tag, "_err"}, 128'(err), 128'(0));
  endtask

  initial begin
    // Reset and idle
    repeat (3) step();
    chk_reset_vals("rst");
    #2 resetn = 1'b1;
    step();
    chk_reset_vals("idle");

    // Fill with out_ready low
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      i = mk(k * 16);
      step();
    end
    in_valid = 1'b0;
    chk("fill_count", 128'(count), 128'(4));
    chk("fill_full", 128'(reg_full), 128'(1));
    chk("fill_in_ready", 128'(in_ready), 128'(0));
    chk("fill_o0", 128'(o[0]), 128'(8'h00));
    chk("fill_o15", 128'(o[15]), 128'(8'h0F));

    // Drain in order
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_word", o, mk(k * 16));
      step();
    end
    out_ready = 1'b0;
    chk("drain_empty", 128'(reg_empty), 128'(1));

    // Steady push/pop at count 2 across several wraps
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      i = mk(8'h40 + k * 16);
      step();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      i = mk(8'h60 + k * 16);
      chk("pp_head", o, mk(8'h40 + k * 16));
      step();
      chk("pp_count", 128'(count), 128'(2));
    end
    in_valid = 1'b0;
    step();
    step();
    out_ready = 1'b0;
    chk("pp_empty", 128'(reg_empty), 128'(1));

    // Full with simultaneous pop and push offer
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      i = mk(8'h11 + k * 16);
      step();
    end
    i = mk(8'hA0);
    out_ready = 1'b1;
    step();
    chk("fpp_count3", 128'(count), 128'(3));
    chk("fpp_head", o, mk(8'h21));
    out_ready = 1'b0;
    step();
    chk("fpp_count4", 128'(count), 128'(4));
    in_valid = 1'b0;
    chk("fpp_err", 128'(err), 128'(0));

    // Flush with a pending push and pop
    out_ready = 1'b1;
    step();
    chk("fl_pre_count", 128'(count), 128'(3));
    flush = 1'b1;
    in_valid = 1'b1;
    i = mk(8'hC0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("fl_count", 128'(count), 128'(0));
    chk("fl_o", o, 128'(0));
    chk("fl_err", 128'(err), 128'(0));
    step();
    chk("fl_still_empty", 128'(reg_empty), 128'(1));

    // Protocol error: stall at full, then drop in_valid
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      i = mk(8'h80 + k);
      step();
    end
    in_valid = 1'b0;
    chk("pe_before", 128'(err), 128'(0));
    step();
    chk("pe_set", 128'(err), 128'(1));
    out_ready = 1'b1;
    repeat (5) step();
    out_ready = 1'b0;
    chk("pe_sticky", 128'(err), 128'(1));
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("pe_cleared", 128'(err), 128'(0));

    // Asynchronous reset mid-stream
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      i = mk(8'h30 + k);
      step();
    end
    in_valid = 1'b0;
    chk("ar_pre_count", 128'(count), 128'(2));
    #2 resetn = 1'b0;
    #1;
    chk_reset_vals("ar");
    step();
    #2 resetn = 1'b1;
    step();
    chk_reset_vals("ar_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mod_statebuf.md
# mod_statebuf

Parametrised, handshaked buffer for AES state words (N_BYTES bytes of BYTE_W bits) between pipeline stages of the AES256 core. It generalises the single-slot 16-byte stage register into a DEPTH-entry first-word-fall-through queue. It uses valid/ready flow control on both sides, with occupancy count, full/empty flags, synchronous flush and a sticky protocol-error flag. It sits between round-function stages (SubBytes/ShiftRows/MixColumns/AddRoundKey) and absorbs backpressure without losing blocks.

## Interface
- N_BYTES, 16, bytes per state word
- BYTE_W, 8, bits per byte
- DEPTH, 4, entries; power of two, >= 2
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of all contents
- in_valid  in  1  producer presents word on i
- in_ready  out  1  buffer can accept this cycle
- i  in  [N_BYTES-1:0][BYTE_W-1:0]  input state word
- out_valid  out  1  head word available on o
- out_ready  in  1  consumer takes head this cycle
- o  out  [N_BYTES-1:0][BYTE_W-1:0]  head word
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
- reg_full  out  1  count == DEPTH
- reg_empty  out  1  count == 0
- err  out  1  sticky: in_valid dropped (deasserted) while in_ready low after being presented, i.e. producer violated hold rule

## Operation
- Push when in_valid && in_ready; pop when out_valid && out_ready.
- in_ready = !reg_full (registered state, no combinational path from out_ready).
- out_valid = !reg_empty. o = head entry when out_valid, else all zeros.
- Push and pop in the same cycle: count unchanged, both pointers advance. When full, push is blocked even if popping; when empty, the pop is ignored.
- Write/read pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0. count is tracked explicitly, not derived from pointers.
- flush has priority over push/pop: pointers and count go to 0, storage is zeroed, and err is cleared.
- err sets when the previous cycle had in_valid && !in_ready and the current cycle has in_valid low. err clears only on reset or flush.
- Byte order preserved: i[k] is emitted on o[k].

## Timing
- Reset (async assert, sync-safe deassert by system):
  - in_ready=1, out_valid=0, o=0, count=0, reg_full=0, reg_empty=1, err=0.
  - Storage and pointers are zeroed.
- Latency is 1 cycle: a word pushed at edge n appears on o with out_valid=1 after edge n (visible in cycle n+1).
- o is stable while out_valid && !out_ready.
- reg_full, reg_empty and count update on the same edge as the push/pop that changes them.
- Throughput is one word per cycle in steady state; there is no bubble at the wrap-around.
- Reset mid-operation: all contents are lost and outputs return to their reset values immediately.

## Structure
- Shared package aes_pkg holds:
  - constants AES_BYTE_W=8 and AES_BLOCK_BYTES=16;
  - typedef aes_state_t (packed [15:0][7:0]), used as the default word type by instantiating blocks.
- One natural sub-module, mod_ptr_ctr: a parametrised wrapping pointer counter with inc, clr (flush) and async reset. It is instantiated twice, once for read and once for write.
- Storage is a plain register array sized DEPTH x N_BYTES x BYTE_W. No RAM macro.

## Test plan
- Reset/idle: hold resetn=0, then release. Check in_ready=1, reg_empty=1, count=0, o=0. Assert resetn low mid-stream; outputs return to reset values with no clock edge.
- Fill/drain (DEPTH=4): push words 0x00..0F, 0x10..1F, 0x20..2F, 0x30..3F with out_ready=0. Check count=4, reg_full=1, in_ready=0, o[0]=0x00. Then set out_ready=1: words come out in order, one per cycle, ending with reg_empty=1.
- Simultaneous push/pop at count=2 for 10 cycles: count stays 2, pointers wrap, and the output sequence matches the input with no drops.
- Full + pop + push: at count=4 assert in_valid and out_ready together. Pop occurs, push is refused that cycle, count=3, and next cycle the push is accepted (count=4).
- Flush: with count=3 and in_valid=1 and out_ready=1, assert flush. Next cycle count=0, o=0, the pending push is not stored, and err=0.
- Protocol error: at full, present in_valid=1 for one cycle, then drop it with in_ready still 0. Check err=1, and that it stays set until flush.
